// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: commit class encoding and datapath widths.
package expipe_pkg;

    localparam int unsigned XLEN           = 64;
    localparam int unsigned REG_IDX_LEN    = 5;
    localparam int unsigned ROB_EXCEPT_LEN = 5;

    typedef enum logic [1:0] {
        ClassNone  = 2'd0,
        ClassInt   = 2'd1,
        ClassFp    = 2'd2,
        ClassStore = 2'd3
    } commit_class_t;

endpackage

// File: rtl/commit_counter.sv
// Wrapping event counter with enable; cleared only by the asynchronous reset.
module commit_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + Width'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/commit_cu.sv
// Commit control unit: retires the ROB head into the register files or store buffer.
// Optional FP writeback path is enabled by defining LEN5_FP_EN.
module commit_cu
    import expipe_pkg::*;
#(
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rob_valid_i,
    output logic                      rob_ready_o,
    input  logic [1:0]                rob_class_i,
    input  logic [REG_IDX_LEN-1:0]    rob_rd_idx_i,
    input  logic [XLEN-1:0]           rob_value_i,
    input  logic                      rob_except_raised_i,
    input  logic [ROB_EXCEPT_LEN-1:0] rob_except_code_i,
    input  logic [XLEN-1:0]           rob_pc_i,
    input  logic                      sb_store_committing_i,
    input  logic                      int_rf_ready_i,
    input  logic                      fp_rf_ready_i,
    output logic                      int_rf_valid_o,
    output logic                      fp_rf_valid_o,
    output logic [REG_IDX_LEN-1:0]    rf_rd_idx_o,
    output logic [XLEN-1:0]           rf_value_o,
    output logic                      flush_o,
    output logic [ROB_EXCEPT_LEN-1:0] except_code_o,
    output logic [XLEN-1:0]           except_pc_o,
    output logic [INSTRET_W-1:0]      instret_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWbInt,
`ifdef LEN5_FP_EN
        StWbFp,
`endif
        StWaitSt,
        StExcept
    } state_t;

    state_t                    r_state;
    state_t                    w_state_d;
    commit_class_t             w_class;
    logic                      w_rob_ready;
    logic                      w_instret_en;
    logic                      w_rf_load;
    logic                      w_except_load;
    logic [REG_IDX_LEN-1:0]    r_rf_rd_idx;
    logic [XLEN-1:0]           r_rf_value;
    logic [ROB_EXCEPT_LEN-1:0] r_except_code;
    logic [XLEN-1:0]           r_except_pc;

    assign w_class = commit_class_t'(rob_class_i);

    always_comb begin
        w_state_d     = r_state;
        w_rob_ready   = 1'b0;
        w_instret_en  = 1'b0;
        w_rf_load     = 1'b0;
        w_except_load = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (rob_valid_i) begin
                    // Exceptions win over the class; the head is popped in StExcept.
                    if (rob_except_raised_i) begin
                        w_except_load = 1'b1;
                        w_state_d     = StExcept;
                    end else begin
                        case (w_class)
                            ClassNone: begin
                                w_rob_ready  = 1'b1;
                                w_instret_en = 1'b1;
                            end
                            ClassInt: begin
                                w_rob_ready = 1'b1;
                                if (rob_rd_idx_i == '0) begin
                                    w_instret_en = 1'b1;
                                end else begin
                                    w_rf_load = 1'b1;
                                    w_state_d = StWbInt;
                                end
                            end
                            ClassFp: begin
                                w_rob_ready = 1'b1;
`ifdef LEN5_FP_EN
                                w_rf_load   = 1'b1;
                                w_state_d   = StWbFp;
`else
                                w_instret_en = 1'b1;
`endif
                            end
                            ClassStore: begin
                                if (sb_store_committing_i) begin
                                    w_rob_ready  = 1'b1;
                                    w_instret_en = 1'b1;
                                end else begin
                                    w_state_d = StWaitSt;
                                end
                            end
                        endcase
                    end
                end
            end
            StWbInt: begin
                if (int_rf_ready_i) begin
                    w_instret_en = 1'b1;
                    w_state_d    = StIdle;
                end
            end
`ifdef LEN5_FP_EN
            StWbFp: begin
                if (fp_rf_ready_i) begin
                    w_instret_en = 1'b1;
                    w_state_d    = StIdle;
                end
            end
`endif
            StWaitSt: begin
                if (sb_store_committing_i) begin
                    w_rob_ready  = 1'b1;
                    w_instret_en = 1'b1;
                    w_state_d    = StIdle;
                end
            end
            StExcept: begin
                w_rob_ready = 1'b1;
                w_state_d   = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= StIdle;
            r_rf_rd_idx   <= '0;
            r_rf_value    <= '0;
            r_except_code <= '0;
            r_except_pc   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_rf_load) begin
                r_rf_rd_idx <= rob_rd_idx_i;
                r_rf_value  <= rob_value_i;
            end
            if (w_except_load) begin
                r_except_code <= rob_except_code_i;
                r_except_pc   <= rob_pc_i;
            end
        end
    end

    commit_counter #(
        .Width (INSTRET_W)
    ) u_instret (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (w_instret_en),
        .count_o (instret_o)
    );

    assign rob_ready_o    = w_rob_ready;
    assign int_rf_valid_o = (r_state == StWbInt);
`ifdef LEN5_FP_EN
    assign fp_rf_valid_o  = (r_state == StWbFp);
`else
    logic w_unused_fp_ready;
    assign w_unused_fp_ready = fp_rf_ready_i;
    assign fp_rf_valid_o     = 1'b0;
`endif
    assign rf_rd_idx_o    = r_rf_rd_idx;
    assign rf_value_o     = r_rf_value;
    assign flush_o        = (r_state == StExcept);
    assign except_code_o  = r_except_code;
    assign except_pc_o    = r_except_pc;

endmodule

// File: tb/tb_commit_cu.sv
// Directed self-checking bench for commit_cu (4-bit instret to exercise wrap).
module tb_commit_cu;
    import expipe_pkg::*;

    localparam int unsigned IW = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_n_i;
    logic                      rob_valid_i;
    logic                      rob_ready_o;
    logic [1:0]                rob_class_i;
    logic [REG_IDX_LEN-1:0]    rob_rd_idx_i;
    logic [XLEN-1:0]           rob_value_i;
    logic                      rob_except_raised_i;
    logic [ROB_EXCEPT_LEN-1:0] rob_except_code_i;
    logic [XLEN-1:0]           rob_pc_i;
    logic                      sb_store_committing_i;
    logic                      int_rf_ready_i;
    logic                      fp_rf_ready_i;
    logic                      int_rf_valid_o;
    logic                      fp_rf_valid_o;
    logic [REG_IDX_LEN-1:0]    rf_rd_idx_o;
    logic [XLEN-1:0]           rf_value_o;
    logic                      flush_o;
    logic [ROB_EXCEPT_LEN-1:0] except_code_o;
    logic [XLEN-1:0]           except_pc_o;
    logic [IW-1:0]             instret_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [IW-1:0] exp_ir = '0;
    int unsigned   wb_cycles;

    always #5 clk_i = ~clk_i;

    commit_cu #(
        .INSTRET_W (IW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .rob_valid_i           (rob_valid_i),
        .rob_ready_o           (rob_ready_o),
        .rob_class_i           (rob_class_i),
        .rob_rd_idx_i          (rob_rd_idx_i),
        .rob_value_i           (rob_value_i),
        .rob_except_raised_i   (rob_except_raised_i),
        .rob_except_code_i     (rob_except_code_i),
        .rob_pc_i              (rob_pc_i),
        .sb_store_committing_i (sb_store_committing_i),
        .int_rf_ready_i        (int_rf_ready_i),
        .fp_rf_ready_i         (fp_rf_ready_i),
        .int_rf_valid_o        (int_rf_valid_o),
        .fp_rf_valid_o         (fp_rf_valid_o),
        .rf_rd_idx_o           (rf_rd_idx_o),
        .rf_value_o            (rf_value_o),
        .flush_o               (flush_o),
        .except_code_o         (except_code_o),
        .except_pc_o           (except_pc_o),
        .instret_o             (instret_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic head(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                        input logic [63:0] val);
        rob_valid_i  = v;
        rob_class_i  = cls;
        rob_rd_idx_i = rd;
        rob_value_i  = val;
    endtask

    initial begin
        rst_n_i               = 1'b0;
        rob_except_raised_i   = 1'b0;
        rob_except_code_i     = '0;
        rob_pc_i              = '0;
        sb_store_committing_i = 1'b0;
        int_rf_ready_i        = 1'b0;
        fp_rf_ready_i         = 1'b0;
        head(1'b0, 2'd0, 5'd0, 64'd0);
        #12;
        check_eq("rst_ready", rob_ready_o, 0);
        check_eq("rst_flush", flush_o, 0);
        check_eq("rst_instret", instret_o, 0);
        check_eq("rst_int_valid", int_rf_valid_o, 0);
        check_eq("rst_fp_valid", fp_rf_valid_o, 0);
        check_eq("rst_rf_idx", rf_rd_idx_o, 0);
        check_eq("rst_rf_value", rf_value_o, 0);
        check_eq("rst_exc_code", except_code_o, 0);
        check_eq("rst_exc_pc", except_pc_o, 0);
        rst_n_i = 1'b1;
        tick();

        // Idle with no valid head
        #1 check_eq("idle_noready", rob_ready_o, 0);
        tick();
        check_eq("idle_instret", instret_o, 0);

        // INT rd=5, RF stalls three cycles
        head(1'b1, ClassInt, 5'd5, 64'hDEAD);
        #1 check_eq("int_pop", rob_ready_o, 1);
        check_eq("int_valid_pre", int_rf_valid_o, 0);
        tick();
        head(1'b1, ClassNone, 5'd0, 64'd0);
        wb_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            int_rf_ready_i = (i == 3);
            #1;
            if (int_rf_valid_o) wb_cycles++;
            check_eq("wb_rd", rf_rd_idx_o, 5);
            check_eq("wb_val", rf_value_o, 64'hDEAD);
            check_eq("wb_nopop", rob_ready_o, 0);
            check_eq("wb_instret", instret_o, 0);
            tick();
        end
        int_rf_ready_i = 1'b0;
        head(1'b0, ClassNone, 5'd0, 64'd0);
        exp_ir++;
        #1 check_eq("wb_cycles", wb_cycles, 4);
        check_eq("wb_done_valid", int_rf_valid_o, 0);
        check_eq("wb_done_instret", instret_o, exp_ir);

        // INT rd=0 retires without a write
        head(1'b1, ClassInt, 5'd0, 64'h1234);
        #1 check_eq("rd0_pop", rob_ready_o, 1);
        tick();
        head(1'b0, ClassNone, 5'd0, 64'd0);
        exp_ir++;
        check_eq("rd0_no_write", int_rf_valid_o, 0);
        check_eq("rd0_instret", instret_o, exp_ir);

        // STORE waits two cycles for the store buffer
        head(1'b1, ClassStore, 5'd0, 64'd0);
        #1 check_eq("st_wait1", rob_ready_o, 0);
        tick();
        check_eq("st_wait2", rob_ready_o, 0);
        tick();
        check_eq("st_wait_instret", instret_o, exp_ir);
        sb_store_committing_i = 1'b1;
        #1 check_eq("st_pop", rob_ready_o, 1);
        tick();
        sb_store_committing_i = 1'b0;
        head(1'b0, ClassNone, 5'd0, 64'd0);
        exp_ir++;
        check_eq("st_instret", instret_o, exp_ir);

        // STORE accepted immediately
        head(1'b1, ClassStore, 5'd0, 64'd0);
        sb_store_committing_i = 1'b1;
        #1 check_eq("sthit_pop", rob_ready_o, 1);
        tick();
        sb_store_committing_i = 1'b0;
        head(1'b0, ClassNone, 5'd0, 64'd0);
        exp_ir++;
        check_eq("sthit_instret", instret_o, exp_ir);

        // Exception code 2 at pc 0x80
        head(1'b1, ClassInt, 5'd7, 64'h77);
        rob_except_raised_i = 1'b1;
        rob_except_code_i   = 5'd2;
        rob_pc_i            = 64'h80;
        #1 check_eq("exc_nopop", rob_ready_o, 0);
        check_eq("exc_noflush", flush_o, 0);
        tick();
        check_eq("exc_flush", flush_o, 1);
        check_eq("exc_pop", rob_ready_o, 1);
        check_eq("exc_code", except_code_o, 2);
        check_eq("exc_pc", except_pc_o, 64'h80);
        check_eq("exc_nowb", int_rf_valid_o, 0);
        tick();
        rob_except_raised_i = 1'b0;
        rob_except_code_i   = 5'd9;
        rob_pc_i            = 64'h44;
        head(1'b0, ClassNone, 5'd0, 64'd0);
        #1 check_eq("exc_flush_end", flush_o, 0);
        check_eq("exc_code_hold", except_code_o, 2);
        check_eq("exc_pc_hold", except_pc_o, 64'h80);
        check_eq("exc_instret", instret_o, exp_ir);

`ifdef LEN5_FP_EN
        // Reset while waiting in FP writeback
        head(1'b1, ClassFp, 5'd3, 64'hF00);
        #1 check_eq("fp_pop", rob_ready_o, 1);
        tick();
        head(1'b0, ClassNone, 5'd0, 64'd0);
        check_eq("fp_valid", fp_rf_valid_o, 1);
        check_eq("fp_rd", rf_rd_idx_o, 3);
        rst_n_i = 1'b0;
        #1 check_eq("fp_rst_valid", fp_rf_valid_o, 0);
        check_eq("fp_rst_instret", instret_o, 0);
        rst_n_i = 1'b1;
        exp_ir  = '0;
`else
        // FP committed as NONE
        head(1'b1, ClassFp, 5'd3, 64'hF00);
        #1 check_eq("fp_pop", rob_ready_o, 1);
        tick();
        head(1'b0, ClassNone, 5'd0, 64'd0);
        exp_ir++;
        check_eq("fp_no_write", fp_rf_valid_o, 0);
        check_eq("fp_no_int_write", int_rf_valid_o, 0);
        check_eq("fp_instret", instret_o, exp_ir);
`endif

        // Reset abandons a pending INT writeback
        head(1'b1, ClassInt, 5'd9, 64'h55);
        tick();
        head(1'b0, ClassNone, 5'd0, 64'd0);
        check_eq("wbrst_valid_pre", int_rf_valid_o, 1);
        rst_n_i = 1'b0;
        #1 check_eq("wbrst_valid", int_rf_valid_o, 0);
        check_eq("wbrst_rd", rf_rd_idx_o, 0);
        check_eq("wbrst_exc_code", except_code_o, 0);
        check_eq("wbrst_instret", instret_o, 0);
        rst_n_i = 1'b1;
        exp_ir  = '0;
        tick();

        // 16 NONE commits wrap the 4-bit counter
        head(1'b1, ClassNone, 5'd0, 64'd0);
        #1 check_eq("none_pop", rob_ready_o, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_ir++;
        end
        check_eq("wrap_15", instret_o, exp_ir);
        tick();
        exp_ir++;
        head(1'b0, ClassNone, 5'd0, 64'd0);
        check_eq("wrap_0", instret_o, exp_ir);
        check_eq("wrap_zero", instret_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_cu.md
COMMIT_CU -- requirements
Module: commit_cu

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64: width of retired-instruction counter.
REQ-002 SHALL have port clk_i  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have port rob_valid_i  in  1  ROB head entry valid.
REQ-005 SHALL have port rob_ready_o  out  1  pop ROB head this cycle.
REQ-006 SHALL have port rob_class_i  in  2  commit_class_t of head: NONE, INT, FP, STORE.
REQ-007 SHALL have ports rob_rd_idx_i  in  REG_IDX_LEN and rob_value_i  in  XLEN  head destination and result.
REQ-008 SHALL have ports rob_except_raised_i  in  1, rob_except_code_i  in  ROB_EXCEPT_LEN, rob_pc_i  in  XLEN  head exception info.
REQ-009 SHALL have port sb_store_committing_i  in  1  store buffer accepts head store commit.
REQ-010 SHALL have ports int_rf_ready_i, fp_rf_ready_i  in  1; int_rf_valid_o, fp_rf_valid_o  out  1  RF write handshakes.
REQ-011 SHALL have ports rf_rd_idx_o  out  REG_IDX_LEN, rf_value_o  out  XLEN  registered write data, shared by both RFs.
REQ-012 SHALL have ports flush_o  out  1, except_code_o  out  ROB_EXCEPT_LEN, except_pc_o  out  XLEN.
REQ-013 SHALL have port instret_o  out  INSTRET_W  retired-instruction count.

Function
REQ-014 FSM states SHALL be IDLE, WB_INT, WB_FP, WAIT_ST, EXCEPT.
REQ-015 rob_ready_o SHALL be combinational, asserted only in IDLE (per REQ-016..019), WAIT_ST with sb_store_committing_i, or EXCEPT.
REQ-016 IDLE, rob_valid_i & rob_except_raised_i: no pop; latch code/pc into except_code_o/except_pc_o; next EXCEPT. Exception has priority over class.
REQ-017 IDLE, class NONE, or INT with rob_rd_idx_i==0: pop same cycle, instret+1, stay IDLE.
REQ-018 IDLE, class INT (rd!=0) or FP: pop same cycle, register rd/value into rf_rd_idx_o/rf_value_o, next WB_INT or WB_FP.
REQ-019 IDLE, class STORE: pop and instret+1 same cycle if sb_store_committing_i, else next WAIT_ST.
REQ-020 WB_INT/WB_FP: corresponding rf valid held high, data stable, until ready sampled high; that cycle instret+1 and next IDLE; no pop while in WB state.
REQ-021 WAIT_ST: hold until sb_store_committing_i; then pop, instret+1, next IDLE.
REQ-022 EXCEPT: flush_o high exactly one cycle, rob_ready_o high, no instret increment, next IDLE.
REQ-023 except_code_o/except_pc_o SHALL hold until next exception.
REQ-024 instret_o SHALL wrap modulo 2^INSTRET_W.
REQ-025 rob_valid_i low in IDLE: no action. Valid and ready on same cycle as WB completion: head not examined until IDLE.
REQ-026 Throughput: NONE/store-hit 1/cycle; INT/FP 1 per 2 cycles minimum.

Reset
REQ-027 Asynchronous reset SHALL force IDLE, all outputs and registers to 0, abandoning any pending writeback or store wait.

Configuration
REQ-028 Macro LEN5_FP_EN: defined -> FP class uses WB_FP and fp_rf_valid_o; undefined -> WB_FP removed, fp_rf_valid_o tied 0, FP class committed as NONE.

Structure
REQ-029 commit_class_t and its encoding SHALL live in expipe_pkg; FSM state type SHALL be local.
REQ-030 Instret counter SHALL be one sub-module, commit_counter (enable, async clear, wrapping).

Verification
REQ-031 INT rd=5 value 0xDEAD, int_rf_ready_i low 3 cycles -> int_rf_valid_o high 4 cycles, rd/value stable, instret 0->1.
REQ-032 INT rd=0 -> popped same cycle, int_rf_valid_o never asserted, instret+1.
REQ-033 STORE, sb_store_committing_i low 2 cycles then high -> pop on 3rd cycle, instret+1.
REQ-034 exception code 2 at pc 0x80 -> flush_o one-cycle pulse next cycle, except_code_o=2, except_pc_o=0x80, instret unchanged.
REQ-035 INSTRET_W=4, 16 NONE commits -> instret_o wraps to 0.
REQ-036 reset in WB_FP -> fp_rf_valid_o drops immediately, state IDLE; FP with LEN5_FP_EN undefined -> no fp write, instret+1.
